// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
    OP_XOR = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7, OP_DIV = 4'd8, OP_MOD = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, EXEC, ITER} state_e;

  // Raw 4-bit mode so illegal codes 10..15 need no enum cast.
  function automatic logic is_multicycle(logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Shift-add multiplier and restoring divider sharing one adder and one counter.
module alu_muldiv_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           go,
  input  logic           op_div,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod,
  output logic [N-1:0]   quo,
  output logic [N-1:0]   rem
);
  localparam int CNT_W = $clog2(N+1);

  // hi/lo hold the partial product for MUL, remainder/quotient for DIV.
  logic [N-1:0]     hi, lo, b_r;
  logic [CNT_W-1:0] cnt;
  logic             div_r;
  logic [N:0]       add_x, add_y;
  logic [N+1:0]     sum;
  logic             ge;

  // Divide subtracts via x + ~b + 1; carry-out set means shifted remainder >= b.
  always_comb begin
    add_x = div_r ? {hi, lo[N-1]} : {1'b0, hi};
    add_y = div_r ? ~{1'b0, b_r} : (lo[0] ? {1'b0, b_r} : '0);
    sum   = {1'b0, add_x} + {1'b0, add_y} + {{(N+1){1'b0}}, div_r};
    ge    = sum[N+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0; lo <= '0; b_r <= '0; cnt <= '0;
      div_r <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go) begin
        hi    <= '0;
        lo    <= a;
        b_r   <= b;
        div_r <= op_div;
        cnt   <= CNT_W'(N);
        busy  <= 1'b1;
      end else if (busy) begin
        if (div_r) begin
          hi <= ge ? sum[N-1:0] : add_x[N-1:0];
          lo <= {lo[N-2:0], ge};
        end else begin
          hi <= sum[N:1];
          lo <= {sum[0], lo[N-1:1]};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign prod = {hi, lo};
  assign quo  = lo;
  assign rem  = hi;

endmodule

// File: rtl/alu_secuencial.sv
// Clocked N-bit ALU: start/done handshake, registered result and flags, multi-cycle MUL/DIV/MOD.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     mode,
  input  logic [N-1:0]   in1,
  input  logic [N-1:0]   in2,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           neg,
  output logic           cero,
  output logic           carry,
  output logic           des,
  output logic           err
);
  localparam logic [N-1:0] N_V = N'(N);

  state_e           state;
  logic [N-1:0]     a_r, b_r;
  logic [3:0]       op_r;
  logic             md_busy, md_done;
  logic [2*N-1:0]   md_prod;
  logic [N-1:0]     md_quo, md_rem;
  logic             finish, accept, go;
  logic [2*N-1:0]   nxt_res;
  logic             nxt_neg, nxt_carry, nxt_des, nxt_err;
  logic [N:0]       sum;

  // Completion and a fresh accept may share an edge, giving back-to-back ops.
  assign finish = (state == EXEC) || ((state == ITER) && md_done && !md_busy);
  assign accept = start && ((state == IDLE) || finish);
  assign go     = accept && is_multicycle(mode) && !((mode != OP_MUL) && (in2 == '0));

  alu_muldiv_seq #(.N(N)) u_muldiv (
    .clk(clk), .rst_n(rst_n), .go(go), .op_div(mode != OP_MUL),
    .a(in1), .b(in2), .busy(md_busy), .done(md_done),
    .prod(md_prod), .quo(md_quo), .rem(md_rem)
  );

  always_comb begin
    nxt_res = '0; nxt_neg = 1'b0; nxt_carry = 1'b0; nxt_des = 1'b0; nxt_err = 1'b0;
    sum = '0;
    if (state == ITER) begin
      case (op_r)
        OP_MUL:  nxt_res = md_prod;
        OP_DIV:  nxt_res = {{N{1'b0}}, md_quo};
        default: nxt_res = {{N{1'b0}}, md_rem};
      endcase
    end else begin
      case (op_r)
        OP_ADD: begin
          sum = {1'b0, a_r} + {1'b0, b_r};
          nxt_res[N-1:0] = sum[N-1:0];
          nxt_carry = sum[N];
          nxt_neg   = sum[N-1];
          nxt_des   = (a_r[N-1] == b_r[N-1]) && (sum[N-1] != a_r[N-1]);
        end
        OP_SUB: begin
          sum = {1'b0, a_r} - {1'b0, b_r};
          nxt_res[N-1:0] = sum[N-1:0];
          nxt_carry = sum[N];
          nxt_neg   = sum[N-1];
          nxt_des   = (a_r[N-1] != b_r[N-1]) && (sum[N-1] != a_r[N-1]);
        end
        OP_AND: nxt_res[N-1:0] = a_r & b_r;
        OP_OR:  nxt_res[N-1:0] = a_r | b_r;
        OP_XOR: nxt_res[N-1:0] = a_r ^ b_r;
        // One guard bit catches the last bit shifted out.
        OP_SHL: if (b_r < N_V) begin
          sum = {1'b0, a_r} << b_r;
          nxt_res[N-1:0] = sum[N-1:0];
          nxt_carry = sum[N];
        end
        OP_SHR: if (b_r < N_V) begin
          sum = {a_r, 1'b0} >> b_r;
          nxt_res[N-1:0] = sum[N:1];
          nxt_carry = sum[0];
        end
        default: nxt_err = 1'b1;  // DIV/MOD by zero or illegal code
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE; a_r <= '0; b_r <= '0; op_r <= '0;
      busy <= 1'b0; done <= 1'b0; result <= '0;
      neg <= 1'b0; cero <= 1'b1; carry <= 1'b0; des <= 1'b0; err <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        result <= nxt_res;
        neg    <= nxt_neg;
        cero   <= (nxt_res == '0);
        carry  <= nxt_carry;
        des    <= nxt_des;
        err    <= nxt_err;
      end
      if (accept) begin
        a_r   <= in1;
        b_r   <= in2;
        op_r  <= mode;
        state <= go ? ITER : EXEC;
        busy  <= 1'b1;
      end else if (finish) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
